sym_stim_gen: RTL and testbench

Parametrised, synthesisable symbol stimulus source for decoder benches and on-board BIST. It generalises the fixed 60-bit/2-bit serializer:
- Serialises a programmable bit pattern into SYM_W-bit symbols.
- Applies XOR error injection.
- Paces output with a programmable valid-decimation counter.
- Supports downstream backpressure, single-shot or repeat mode, and selectable in-symbol bit order.
It sits in front of fano_decoder (i_vld/i_data) or any soft/hard symbol consumer.

---
 rtl/sym_stim_gen.sv | 158 +++++++++++++++
 tb/tb_sym_stim_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sym_stim_gen.sv
// Symbol stimulus source: serialises a latched bit pattern (with XOR error
// injection) into SYM_W-bit symbols, paced by a valid-decimation counter, with
// downstream backpressure, single-shot/repeat modes and selectable bit order.
//
// Ports:
//   CLK, nRESET     clock, synchronous active-low reset
//   i_start/i_stop  one-cycle start (idle only) / abort (run only) pulses
//   i_pattern       source bits, bit 0 sent first
//   i_err_mask      XOR mask applied to i_pattern at load
//   i_pat_len       valid pattern bits (clamped to MAX_PAT_W)
//   i_period        emission slot every i_period+1 cycles
//   i_repeat        loop the pattern until i_stop
//   i_swap          first pattern bit of a symbol goes to the MSB
//   i_rdy           downstream ready
//   o_vld/o_data    symbol handshake, held until accepted
//   o_last          last symbol of a pass (qualified by o_vld)
//   o_busy          high while running
//   o_done          one-cycle pulse on completion or abort
//   o_sym_cnt       accepted symbols since start, saturating
module sym_stim_gen #(
   parameter int unsigned MAX_PAT_W = 64,
   parameter int unsigned SYM_W     = 2,
   parameter int unsigned LEN_W     = 7,
   parameter int unsigned PER_W     = 6,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 CLK,
   input  logic                 nRESET,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic [MAX_PAT_W-1:0] i_pattern,
   input  logic [MAX_PAT_W-1:0] i_err_mask,
   input  logic [LEN_W-1:0]     i_pat_len,
   input  logic [PER_W-1:0]     i_period,
   input  logic                 i_repeat,
   input  logic                 i_swap,
   input  logic                 i_rdy,
   output logic                 o_vld,
   output logic [SYM_W-1:0]     o_data,
   output logic                 o_last,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CNT_W-1:0]     o_sym_cnt
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q;
   logic [MAX_PAT_W-1:0] pat_q;
   logic [LEN_W-1:0]     ns_q;
   logic [LEN_W-1:0]     k_q;
   logic [PER_W-1:0]     per_q;
   logic [PER_W-1:0]     dec_q;
   logic                 rpt_q;
   logic                 swap_q;
   logic                 vld_q;
   logic [SYM_W-1:0]     data_q;
   logic                 last_q;
   logic                 done_q;
   logic [CNT_W-1:0]     cnt_q;

   logic [LEN_W-1:0]     len_clamp;
   logic [LEN_W-1:0]     ns_load;
   logic [MAX_PAT_W-1:0] pat_load;
   logic [MAX_PAT_W-1:0] pat_shift;
   logic [SYM_W-1:0]     sym;
   logic                 accept;
   logic                 slot;

   always_comb begin
      len_clamp = (i_pat_len > LEN_W'(MAX_PAT_W)) ? LEN_W'(MAX_PAT_W) : i_pat_len;
      ns_load   = LEN_W'((32'(len_clamp) + SYM_W - 1) / SYM_W);
      // Bits beyond the pattern length are zeroed once at load, so a partial
      // final symbol needs no per-symbol masking.
      pat_load  = (i_pattern ^ i_err_mask) & ~({MAX_PAT_W{1'b1}} << len_clamp);
      pat_shift = pat_q >> (k_q * SYM_W);
      sym       = '0;
      for (int unsigned j = 0; j < SYM_W; j++) begin
         if (swap_q) sym[SYM_W-1-j] = pat_shift[j];
         else        sym[j]         = pat_shift[j];
      end
      accept = vld_q & i_rdy;
      slot   = (dec_q == '0);
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q <= StIdle;
         pat_q   <= '0;
         ns_q    <= '0;
         k_q     <= '0;
         per_q   <= '0;
         dec_q   <= '0;
         rpt_q   <= 1'b0;
         swap_q  <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (i_start) begin
                  pat_q  <= pat_load;
                  ns_q   <= ns_load;
                  per_q  <= i_period;
                  rpt_q  <= i_repeat;
                  swap_q <= i_swap;
                  k_q    <= '0;
                  cnt_q  <= '0;
                  dec_q  <= '0;
                  if (len_clamp == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               dec_q <= (dec_q == per_q) ? '0 : dec_q + 1'b1;
               if (accept) begin
                  vld_q  <= 1'b0;
                  last_q <= 1'b0;
                  k_q    <= last_q ? '0 : k_q + 1'b1;
                  if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
               end
               if (i_stop) begin
                  vld_q   <= 1'b0;
                  last_q  <= 1'b0;
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end else if (accept && last_q && !rpt_q) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end else if (!vld_q && slot) begin
                  // A slot that lands while a symbol is still pending is dropped.
                  vld_q  <= 1'b1;
                  data_q <= sym;
                  last_q <= (k_q == ns_q - 1'b1);
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_vld     = vld_q;
   assign o_data    = data_q;
   assign o_last    = last_q;
   assign o_busy    = (state_q == StRun);
   assign o_done    = done_q;
   assign o_sym_cnt = cnt_q;

endmodule

// File: tb/tb_sym_stim_gen.sv
// Directed bench for sym_stim_gen (SYM_W=2, MAX_PAT_W=64).
module tb_sym_stim_gen;

   localparam logic [63:0] FANO = 64'h0A44_ECC4_E757_F7B7;

   logic        CLK = 1'b0;
   logic        nRESET;
   logic        i_start, i_stop, i_repeat, i_swap, i_rdy;
   logic [63:0] i_pattern, i_err_mask;
   logic [6:0]  i_pat_len;
   logic [5:0]  i_period;
   logic        o_vld, o_last, o_busy, o_done;
   logic [1:0]  o_data;
   logic [15:0] o_sym_cnt;

   sym_stim_gen #(
      .MAX_PAT_W(64), .SYM_W(2), .LEN_W(7), .PER_W(6), .CNT_W(16)
   ) dut (
      .CLK       (CLK),
      .nRESET    (nRESET),
      .i_start   (i_start),
      .i_stop    (i_stop),
      .i_pattern (i_pattern),
      .i_err_mask(i_err_mask),
      .i_pat_len (i_pat_len),
      .i_period  (i_period),
      .i_repeat  (i_repeat),
      .i_swap    (i_swap),
      .i_rdy     (i_rdy),
      .o_vld     (o_vld),
      .o_data    (o_data),
      .o_last    (o_last),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_sym_cnt (o_sym_cnt)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   logic [1:0]  acc_data [0:127];
   bit          acc_last [0:127];
   int          acc_cyc  [0:127];
   logic [1:0]  ref_d    [0:31];
   int          n_acc, done_cyc, stable_bad;
   bit          vld_seen, vld_at_done, busy_c1, done_after;
   logic [15:0] cnt_at_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference symbol built bit by bit from the original pattern.
   function automatic logic [1:0] model_sym(input logic [63:0] pat, input int len, input int k,
                                            input bit swp);
      logic [1:0] s;
      s = '0;
      for (int j = 0; j < 2; j++) begin
         int p;
         bit b;
         p = k * 2 + j;
         b = (p < len && p < 64) ? pat[p] : 1'b0;
         if (swp) s[1-j] = b;
         else     s[j]   = b;
      end
      return s;
   endfunction

   // Start a run and follow it until o_done (or max_cyc). rdy_mode 1 drives
   // ready as 1,0,0 repeating. stop_after>0 holds ready low after that many
   // acceptances and pulses i_stop while a symbol is pending.
   task automatic run(input logic [63:0] pat, input logic [63:0] mask, input logic [6:0] len,
                      input logic [5:0] per, input bit rpt, input bit swp, input int rdy_mode,
                      input int stop_after, input int max_cyc);
      bit         prev_hold, stopping;
      logic [1:0] prev_d;
      bit         prev_l;
      n_acc = 0; done_cyc = -1; stable_bad = 0; vld_seen = 0; vld_at_done = 1'b1;
      busy_c1 = 1'b0; cnt_at_done = '1;
      @(negedge CLK);
      i_pattern = pat; i_err_mask = mask; i_pat_len = len; i_period = per;
      i_repeat = rpt; i_swap = swp; i_rdy = 1'b1; i_start = 1'b1;
      prev_hold = 1'b0; stopping = 1'b0; prev_d = '0; prev_l = 1'b0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge CLK);
         i_start = 1'b0;
         if (cyc == 1) busy_c1 = o_busy;
         if (o_vld) vld_seen = 1'b1;
         if (prev_hold && !(o_vld && o_data === prev_d && o_last === prev_l)) stable_bad++;
         if (o_done) begin
            done_cyc = cyc; cnt_at_done = o_sym_cnt; vld_at_done = o_vld; i_stop = 1'b0;
            break;
         end
         if (stop_after > 0 && n_acc >= stop_after) begin
            i_rdy = 1'b0; prev_hold = 1'b0;
            if (o_vld && !stopping) begin i_stop = 1'b1; stopping = 1'b1; end
            else i_stop = 1'b0;
            continue;
         end
         i_rdy = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 1);
         if (o_vld && i_rdy && n_acc < 128) begin
            acc_data[n_acc] = o_data; acc_last[n_acc] = o_last; acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         prev_hold = o_vld && !i_rdy; prev_d = o_data; prev_l = o_last;
      end
      i_stop = 1'b0; i_rdy = 1'b1;
      @(negedge CLK);
      done_after = o_done;
   endtask

   initial begin
      int bad;
      nRESET = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_pattern = '0; i_err_mask = '0;
      i_pat_len = '0; i_period = '0; i_repeat = 1'b0; i_swap = 1'b0; i_rdy = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_vld", o_vld, 0);
      chk("rst_data", o_data, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_cnt", o_sym_cnt, 0);
      nRESET = 1'b1;

      // Fano vector: 30 symbols, one per 64 cycles, swap on.
      run(FANO, 64'h0, 7'd60, 6'd63, 1'b0, 1'b1, 0, 0, 2500);
      chk("fano_busy", busy_c1, 1);
      chk("fano_n", n_acc, 30);
      chk("fano_sym0", acc_data[0], 2'b11);
      chk("fano_sym1", acc_data[1], 2'b10);
      chk("fano_sym3", acc_data[3], 2'b01);
      chk("fano_first_cyc", acc_cyc[0], 2);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         ref_d[i] = model_sym(FANO, 60, i, 1'b1);
         if (acc_data[i] !== ref_d[i] || acc_last[i] !== (i == 29)) bad++;
         if (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 64) bad++;
      end
      chk("fano_seq", bad, 0);
      chk("fano_done_cyc", done_cyc, acc_cyc[29] + 1);
      chk("fano_cnt", cnt_at_done, 30);
      chk("fano_done_pulse", done_after, 0);

      // Mask bit 6 is the first bit of symbol 3, which lands in the MSB when swapped.
      run(FANO, 64'h40, 7'd60, 6'd63, 1'b0, 1'b1, 0, 0, 2500);
      chk("err_n", n_acc, 30);
      chk("err_sym3", acc_data[3], 2'b11);
      bad = 0;
      for (int i = 0; i < 30; i++)
         if (acc_data[i] !== (ref_d[i] ^ ((i == 3) ? 2'b10 : 2'b00))) bad++;
      chk("err_seq", bad, 0);

      // Backpressure: same sequence, held data stable while not ready.
      run(FANO, 64'h0, 7'd60, 6'd0, 1'b0, 1'b1, 1, 0, 1000);
      chk("bp_n", n_acc, 30);
      bad = 0;
      for (int i = 0; i < 30; i++) if (acc_data[i] !== ref_d[i]) bad++;
      chk("bp_seq", bad, 0);
      chk("bp_stable", stable_bad, 0);
      chk("bp_cnt", cnt_at_done, 30);

      // Partial final symbol: bits above len forced to zero.
      run(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 7'd5, 6'd0, 1'b0, 1'b0, 0, 0, 200);
      chk("part_n", n_acc, 3);
      chk("part_s0", acc_data[0], 2'b11);
      chk("part_s1", acc_data[1], 2'b11);
      chk("part_s2", acc_data[2], 2'b01);
      chk("part_last", {acc_last[0], acc_last[1], acc_last[2]}, 3'b001);
      chk("part_cnt", cnt_at_done, 3);

      // Length above MAX_PAT_W clamps to 64 bits.
      run(64'hDEAD_BEEF_0123_4567, 64'h0, 7'd100, 6'd0, 1'b0, 1'b0, 0, 0, 500);
      chk("clamp_n", n_acc, 32);
      chk("clamp_s31", acc_data[31], 2'b11);
      bad = 0;
      for (int i = 0; i < 32; i++)
         if (acc_data[i] !== model_sym(64'hDEAD_BEEF_0123_4567, 64, i, 1'b0) ||
             acc_last[i] !== (i == 31)) bad++;
      chk("clamp_seq", bad, 0);
      chk("clamp_cnt", cnt_at_done, 32);

      // Zero length: straight to done, nothing emitted.
      run(FANO, 64'h0, 7'd0, 6'd0, 1'b0, 1'b0, 0, 0, 50);
      chk("len0_done_cyc", done_cyc, 1);
      chk("len0_vld", vld_seen, 0);
      chk("len0_busy", busy_c1, 0);
      chk("len0_cnt", cnt_at_done, 0);

      // Repeat with stop after 10 acceptances. Low byte 0xB2 -> 10,00,11,10.
      run(64'hFFFF_FFFF_FFFF_FFB2, 64'h0, 7'd8, 6'd1, 1'b1, 1'b0, 0, 10, 500);
      chk("rpt_n", n_acc, 10);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         logic [7:0] exp_seq;
         exp_seq = 8'b10_11_00_10;
         if (acc_data[i] !== exp_seq[2*(i%4) +: 2] || acc_last[i] !== (i % 4 == 3)) bad++;
      end
      chk("rpt_seq", bad, 0);
      chk("rpt_done_seen", done_cyc > 0, 1);
      chk("rpt_stop_vld", vld_at_done, 0);
      chk("rpt_cnt", cnt_at_done, 10);
      chk("rpt_done_pulse", done_after, 0);

      // Reset while a symbol is pending.
      @(negedge CLK);
      i_pattern = FANO; i_err_mask = '0; i_pat_len = 7'd60; i_period = 6'd0;
      i_repeat = 1'b0; i_swap = 1'b1; i_rdy = 1'b0; i_start = 1'b1;
      bad = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         i_start = 1'b0;
         if (o_vld) begin bad = 0; break; end
      end
      chk("mid_vld_seen", bad, 0);
      nRESET = 1'b0;
      @(negedge CLK);
      nRESET = 1'b1;
      chk("mid_vld", o_vld, 0);
      chk("mid_data", o_data, 0);
      chk("mid_last", o_last, 0);
      chk("mid_busy", o_busy, 0);
      chk("mid_done", o_done, 0);
      chk("mid_cnt", o_sym_cnt, 0);
      run(FANO, 64'h0, 7'd60, 6'd0, 1'b0, 1'b1, 0, 0, 500);
      chk("restart_s0", acc_data[0], 2'b11);
      chk("restart_n", n_acc, 30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
